// File: rtl/ins_cache_pkg.sv
// Shared definitions for the instruction cache: bus widths, the cache
// geometry and the refill FSM state encoding.
package ins_cache_pkg;

   // Memory byte-address width and instruction word width.
   localparam int RAM_ADR_W    = 32;
   localparam int DAT_W        = 32;

   // Index width of the instruction cache (2^ICACHE_IDX_W lines).
   localparam int ICACHE_IDX_W = 4;

   // Refill controller states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } state_t;

   // Return 'word' with byte lane 'lane' replaced by 'b' (lane 0 = bits [7:0]).
   function automatic logic [DAT_W-1:0] put_byte(input logic [DAT_W-1:0] word,
                                                  input logic [1:0]       lane,
                                                  input logic [7:0]       b);
      logic [DAT_W-1:0] res;
      res = word;
      res[{lane, 3'b000} +: 8] = b;
      return res;
   endfunction

endpackage

// File: rtl/ins_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Lookup is combinational; a single write port installs a complete line.
module ins_cache_array
   import ins_cache_pkg::*;
#(
   parameter int IDX_W = ICACHE_IDX_W,
   parameter int TAG_W = RAM_ADR_W - ICACHE_IDX_W - 2,
   parameter int DW    = DAT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   input  logic [TAG_W-1:0] rd_tag_i,
   output logic             hit_o,
   output logic [DW-1:0]    rd_data_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic [DW-1:0]    wr_data_i
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [DW-1:0]    data_q [LINES];

   // Valid bits are the only storage that needs a known reset value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data are qualified by the valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   // Combinational lookup of the addressed line.
   always_comb begin
      hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
      rd_data_o = data_q[rd_idx_i];
   end

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits reply one cycle
// after the request; misses refill the line with four little-endian byte
// reads from memory and then reply with the assembled word.
//
// Handshakes:
//  - Fetch side: ins_call is a one-cycle request sampled only in IDLE; the
//    reply is a one-cycle cache_en pulse with cache_ins_out valid alongside.
//  - Memory side: mem_call/mem_addr are held stable until a cycle with
//    mem_ok high is sampled (that cycle carries mem_byte); each accepted
//    byte advances mem_addr by one. mem_ok with mem_call low is ignored.
//  - en low freezes every register, including a pending cache_en pulse.
module ins_cache
   import ins_cache_pkg::*;
#(
   parameter int IDX_W = ICACHE_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 ins_call,
   input  logic [RAM_ADR_W-1:0] addr_in,
   output logic                 cache_en,
   output logic [DAT_W-1:0]     cache_ins_out,
   input  logic                 flush,
   output logic                 mem_call,
   output logic [RAM_ADR_W-1:0] mem_addr,
   input  logic                 mem_ok,
   input  logic [7:0]           mem_byte,
   output logic                 dbg_state_o
);

   localparam int TAG_W = RAM_ADR_W - IDX_W - 2;

   state_t               state_q;
   logic [1:0]           count_q;
   logic [RAM_ADR_W-1:0] line_addr_q;
   logic [DAT_W-1:0]     word_q;
   logic                 cache_en_q;
   logic [DAT_W-1:0]     ins_q;
   logic                 mem_call_q;
   logic [RAM_ADR_W-1:0] mem_addr_q;

   logic                 hit;
   logic [DAT_W-1:0]     rd_data;
   logic                 byte_acc;
   logic                 last_byte;
   logic                 line_we;
   logic [DAT_W-1:0]     fill_word;
   logic [RAM_ADR_W-1:0] aligned_addr;

   // Decode the accepted-byte and line-complete conditions for this cycle.
   always_comb begin
      aligned_addr = {addr_in[RAM_ADR_W-1:2], 2'b00};
      byte_acc     = en && !flush && (state_q == ST_FILL) && mem_call_q && mem_ok;
      last_byte    = byte_acc && (count_q == 2'd3);
      line_we      = last_byte;
      fill_word    = put_byte(word_q, count_q, mem_byte);
   end

   ins_cache_array #(
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .DW    (DAT_W)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_i  (addr_in[IDX_W+1:2]),
      .rd_tag_i  (addr_in[RAM_ADR_W-1:IDX_W+2]),
      .hit_o     (hit),
      .rd_data_o (rd_data),
      .we_i      (line_we),
      .wr_idx_i  (line_addr_q[IDX_W+1:2]),
      .wr_tag_i  (line_addr_q[RAM_ADR_W-1:IDX_W+2]),
      .wr_data_i (fill_word)
   );

   // Refill FSM with registered reply and memory-request outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         count_q     <= 2'd0;
         line_addr_q <= '0;
         word_q      <= '0;
         cache_en_q  <= 1'b0;
         ins_q       <= '0;
         mem_call_q  <= 1'b0;
         mem_addr_q  <= '0;
      end else if (en) begin
         if (flush) begin
            // Abort: drop any partial word and any same-cycle request.
            state_q    <= ST_IDLE;
            mem_call_q <= 1'b0;
            cache_en_q <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cache_en_q <= 1'b0;
                  if (ins_call) begin
                     if (hit) begin
                        cache_en_q <= 1'b1;
                        ins_q      <= rd_data;
                     end else begin
                        line_addr_q <= aligned_addr;
                        mem_addr_q  <= aligned_addr;
                        mem_call_q  <= 1'b1;
                        count_q     <= 2'd0;
                        state_q     <= ST_FILL;
                     end
                  end
               end
               ST_FILL: begin
                  cache_en_q <= 1'b0;
                  if (byte_acc) begin
                     word_q     <= fill_word;
                     count_q    <= count_q + 2'd1;
                     mem_addr_q <= mem_addr_q + RAM_ADR_W'(1);
                     if (last_byte) begin
                        cache_en_q <= 1'b1;
                        ins_q      <= fill_word;
                        mem_call_q <= 1'b0;
                        state_q    <= ST_IDLE;
                     end
                  end
               end
               default: begin
                  state_q    <= ST_IDLE;
                  mem_call_q <= 1'b0;
                  cache_en_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cache_en      = cache_en_q;
   assign cache_ins_out = ins_q;
   assign mem_call      = mem_call_q;
   assign mem_addr      = mem_addr_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ins_cache.sv
// Directed testbench for ins_cache: hits, cold/conflict misses, unaligned
// fetches, stalled memory, flush, en freeze and asynchronous reset.
module tb_ins_cache;
  import ins_cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 en = 1'b1;
  logic                 ins_call = 1'b0;
  logic [RAM_ADR_W-1:0] addr_in = '0;
  logic                 cache_en;
  logic [DAT_W-1:0]     cache_ins_out;
  logic                 flush = 1'b0;
  logic                 mem_call;
  logic [RAM_ADR_W-1:0] mem_addr;
  logic                 mem_ok = 1'b0;
  logic [7:0]           mem_byte = '0;
  logic                 dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ins_cache dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .ins_call      (ins_call),
    .addr_in       (addr_in),
    .cache_en      (cache_en),
    .cache_ins_out (cache_ins_out),
    .flush         (flush),
    .mem_call      (mem_call),
    .mem_addr      (mem_addr),
    .mem_ok        (mem_ok),
    .mem_byte      (mem_byte),
    .dbg_state_o   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issue a one-cycle fetch request, return just after the sampling edge
  task automatic issue(input logic [31:0] a, input logic with_flush);
    ins_call = 1'b1;
    addr_in  = a;
    flush    = with_flush;
    tick();
    ins_call = 1'b0;
    flush    = 1'b0;
  endtask

  // driver: memory model serving nbytes of 'word' starting at 'base', with
  // 'stall' idle cycles before each byte; checks the request stays stable
  task automatic serve(input logic [31:0] base, input logic [31:0] word,
                       input int stall, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      for (int s = 0; s < stall; s++) begin
        mem_ok = 1'b0;
        n_checks++;
        if (mem_call !== 1'b1 || mem_addr !== base + 32'(i)) begin
          n_errors++;
          $display("FAIL stall_hold byte %0d: mem_call=%b mem_addr=%h expected 1/%h",
                   i, mem_call, mem_addr, base + 32'(i));
        end
        tick();
      end
      n_checks++;
      if (mem_call !== 1'b1 || mem_addr !== base + 32'(i)) begin
        n_errors++;
        $display("FAIL mem_req byte %0d: mem_call=%b mem_addr=%h expected 1/%h",
                 i, mem_call, mem_addr, base + 32'(i));
      end
      mem_ok   = 1'b1;
      mem_byte = word[8*i +: 8];
      tick();
      mem_ok = 1'b0;
      if (i < 3) begin
        n_checks++;
        if (cache_en !== 1'b0) begin
          n_errors++;
          $display("FAIL early_reply byte %0d: cache_en=%b expected 0", i, cache_en);
        end
      end
    end
    if (nbytes == 4) begin
      n_checks++;
      if (cache_en !== 1'b1 || cache_ins_out !== word || mem_call !== 1'b0) begin
        n_errors++;
        $display("FAIL refill_reply %h: cache_en=%b data=%h mem_call=%b expected 1/%h/0",
                 base, cache_en, cache_ins_out, mem_call, word);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (cache_en !== 1'b0 || cache_ins_out !== '0 || mem_call !== 1'b0 ||
        mem_addr !== '0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL reset_state: en=%b ins=%h call=%b addr=%h st=%b expected all 0",
               cache_en, cache_ins_out, mem_call, mem_addr, dbg_state);
    end
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_cold_miss_hit();
    issue(32'h10, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h10 || cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL cold_miss: call=%b addr=%h en=%b expected 1/00000010/0",
               mem_call, mem_addr, cache_en);
    end
    serve(32'h10, 32'h0010_0513, 0, 4);
    issue(32'h10, 1'b0);
    n_checks++;
    if (cache_en !== 1'b1 || cache_ins_out !== 32'h0010_0513 || mem_call !== 1'b0) begin
      n_errors++;
      $display("FAIL hit_0x10: en=%b data=%h call=%b expected 1/00100513/0",
               cache_en, cache_ins_out, mem_call);
    end
    tick();
    n_checks++;
    if (cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL hit_pulse: cache_en=%b expected 0", cache_en);
    end
  endtask

  task automatic test_conflict();
    issue(32'h50, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h50 || cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL conflict_0x50: call=%b addr=%h en=%b expected 1/00000050/0",
               mem_call, mem_addr, cache_en);
    end
    serve(32'h50, 32'hDEAD_BEEF, 0, 4);
    tick();
    issue(32'h10, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h10 || cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL conflict_0x10: call=%b addr=%h en=%b expected 1/00000010/0",
               mem_call, mem_addr, cache_en);
    end
    serve(32'h10, 32'h0010_0513, 0, 4);
  endtask

  task automatic test_unaligned();
    issue(32'h73, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h70) begin
      n_errors++;
      $display("FAIL unaligned_start: call=%b addr=%h expected 1/00000070", mem_call, mem_addr);
    end
    serve(32'h70, 32'hA5A5_5A5A, 0, 4);
    issue(32'h70, 1'b0);
    n_checks++;
    if (cache_en !== 1'b1 || cache_ins_out !== 32'hA5A5_5A5A) begin
      n_errors++;
      $display("FAIL unaligned_hit: en=%b data=%h expected 1/a5a55a5a", cache_en, cache_ins_out);
    end
    tick();
  endtask

  task automatic test_stall();
    int replies;
    issue(32'h40, 1'b0);
    serve(32'h40, 32'hCAFE_F00D, 3, 4);
    replies = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cache_en === 1'b1) replies++;
    end
    n_checks++;
    if (replies != 0) begin
      n_errors++;
      $display("FAIL stall_single_reply: extra replies=%0d expected 0", replies);
    end
  endtask

  task automatic test_flush_mid();
    int replies;
    issue(32'h20, 1'b0);
    serve(32'h20, 32'h0102_0304, 0, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (mem_call !== 1'b0 || cache_en !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL flush_abort: call=%b en=%b st=%b expected 0/0/0",
               mem_call, cache_en, dbg_state);
    end
    replies = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ok = 1'b1;
      tick();
      if (cache_en === 1'b1) replies++;
    end
    mem_ok = 1'b0;
    n_checks++;
    if (replies != 0) begin
      n_errors++;
      $display("FAIL flush_no_reply: replies=%0d expected 0", replies);
    end
    issue(32'h20, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h20 || cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_remiss: call=%b addr=%h en=%b expected 1/00000020/0",
               mem_call, mem_addr, cache_en);
    end
    serve(32'h20, 32'h0102_0304, 0, 4);
    tick();
  endtask

  task automatic test_flush_with_call();
    issue(32'h10, 1'b1);
    n_checks++;
    if (cache_en !== 1'b0 || mem_call !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_beats_call: en=%b call=%b expected 0/0", cache_en, mem_call);
    end
    issue(32'h10, 1'b0);
    n_checks++;
    if (cache_en !== 1'b1 || cache_ins_out !== 32'h0010_0513) begin
      n_errors++;
      $display("FAIL hit_after_flush: en=%b data=%h expected 1/00100513", cache_en, cache_ins_out);
    end
    tick();
  endtask

  task automatic test_en_freeze();
    issue(32'h80, 1'b0);
    en       = 1'b0;
    mem_ok   = 1'b1;
    mem_byte = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (mem_call !== 1'b1 || mem_addr !== 32'h80 || cache_en !== 1'b0) begin
        n_errors++;
        $display("FAIL en_freeze cycle %0d: call=%b addr=%h en=%b expected 1/00000080/0",
                 i, mem_call, mem_addr, cache_en);
      end
    end
    mem_ok = 1'b0;
    en     = 1'b1;
    serve(32'h80, 32'h5566_7788, 0, 4);
    tick();
  endtask

  task automatic test_reset_mid_fill();
    issue(32'h90, 1'b0);
    serve(32'h90, 32'h1111_2222, 0, 1);
    rst = 1'b0;
    #1;
    n_checks++;
    if (cache_en !== 1'b0 || cache_ins_out !== '0 || mem_call !== 1'b0 ||
        mem_addr !== '0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL async_reset: en=%b ins=%h call=%b addr=%h st=%b expected all 0",
               cache_en, cache_ins_out, mem_call, mem_addr, dbg_state);
    end
    #3 rst = 1'b1;
    tick();
    issue(32'h10, 1'b0);
    n_checks++;
    if (mem_call !== 1'b1 || mem_addr !== 32'h10 || cache_en !== 1'b0) begin
      n_errors++;
      $display("FAIL miss_after_reset: call=%b addr=%h en=%b expected 1/00000010/0",
               mem_call, mem_addr, cache_en);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (mem_call !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_errors++;
      $display("FAIL flush_after_reset: call=%b st=%b expected 0/0", mem_call, dbg_state);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_conflict();
    test_unaligned();
    test_stall();
    test_flush_mid();
    test_flush_with_call();
    test_en_freeze();
    test_reset_mid_fill();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
